// File: rtl/axi_rd_burst_sched.sv
// Read DMA burst scheduler: splits one transfer into AXI INCR bursts (MAX_BURST cap, no 4 KB crossing)
// and tracks outstanding bursts through R-channel last beats.
module axi_rd_burst_sched #(
   parameter int ADDR_W          = 64,
   parameter int DATA_W          = 512,
   parameter int MAX_BURST       = 256,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_read,
   input  logic [ADDR_W-1:0] read_start_addr,
   input  logic [31:0]       read_length,
   output logic              start_ready,
   output logic              ar_valid,
   input  logic              ar_ready,
   output logic [ADDR_W-1:0] ar_addr,
   output logic [7:0]        ar_len,
   output logic [2:0]        ar_size,
   output logic [1:0]        ar_burst,
   input  logic              r_valid,
   input  logic              r_ready,
   input  logic              r_last,
   input  logic [1:0]        r_resp,
   output logic              read_done,
   output logic              read_err
);
   localparam int BB = DATA_W / 8;
   localparam int SZ = $clog2(BB);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       rem_q, rem_d;
   logic [OW-1:0]     outst_q, outst_d;
   logic              err_q, err_d;
   logic [31:0]       room, bsize;
   logic              ar_hs, r_hs, r_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         outst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         outst_q <= outst_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      outst_d = outst_q;
      err_d   = err_q;
      // beats left before the next 4 KB page boundary
      room    = (32'd4096 - {20'd0, addr_q[11:0]}) >> SZ;
      bsize   = rem_q;
      if (bsize > 32'(MAX_BURST)) bsize = 32'(MAX_BURST);
      if (bsize > room) bsize = room;
      ar_hs = ar_valid && ar_ready;
      r_hs  = r_valid && r_ready;
      // a stray last beat with nothing outstanding must not underflow the counter
      r_end = r_hs && r_last && (outst_q != '0);
      if (ar_hs && !r_end)      outst_d = outst_q + 1'b1;
      else if (!ar_hs && r_end) outst_d = outst_q - 1'b1;
      if ((state_q == ISSUE || state_q == DRAIN) && r_hs && (r_resp == 2'b10 || r_resp == 2'b11))
         err_d = 1'b1;
      case (state_q)
         IDLE: if (init_read) begin
            addr_d  = read_start_addr & ~ADDR_W'(BB - 1);
            rem_d   = read_length;
            err_d   = 1'b0;
            state_d = (read_length == 32'd0) ? DONE : ISSUE;
         end
         ISSUE: if (ar_hs) begin
            addr_d = addr_q + (ADDR_W'(bsize) << SZ);
            rem_d  = rem_q - bsize;
            if (rem_q == bsize) state_d = DRAIN;
         end
         DRAIN: if (outst_q == '0) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign start_ready = (state_q == IDLE);
   assign ar_valid    = (state_q == ISSUE) && (outst_q < OW'(MAX_OUTSTANDING));
   assign ar_addr     = addr_q;
   assign ar_len      = (state_q == ISSUE) ? 8'(bsize - 32'd1) : 8'd0;
   assign ar_size     = 3'(SZ);
   assign ar_burst    = 2'b01;
   assign read_done   = (state_q == DONE);
   assign read_err    = err_q;

endmodule

// File: tb/tb_axi_rd_burst_sched.sv
// Randomized bench for axi_rd_burst_sched: an AR/R responder plus a burst-split reference model.
module tb_axi_rd_burst_sched;
   localparam int ADDR_W = 64, DATA_W = 512, MAX_BURST = 256, MAX_OUT = 4, BB = DATA_W / 8;

   logic              clk = 1'b0, rst = 1'b1;
   logic              init_read = 1'b0;
   logic [ADDR_W-1:0] read_start_addr = '0;
   logic [31:0]       read_length = '0;
   logic              start_ready, ar_valid, ar_ready = 1'b0;
   logic [ADDR_W-1:0] ar_addr;
   logic [7:0]        ar_len;
   logic [2:0]        ar_size;
   logic [1:0]        ar_burst;
   logic              r_valid = 1'b0, r_ready = 1'b1, r_last = 1'b0;
   logic [1:0]        r_resp = 2'b00;
   logic              read_done, read_err;

   always #5 clk = ~clk;

   axi_rd_burst_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST),
                        .MAX_OUTSTANDING(MAX_OUT)) dut (
      .clk(clk), .rst(rst), .init_read(init_read), .read_start_addr(read_start_addr),
      .read_length(read_length), .start_ready(start_ready), .ar_valid(ar_valid),
      .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
      .ar_burst(ar_burst), .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
      .r_resp(r_resp), .read_done(read_done), .read_err(read_err));

   int errs = 0, checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // responder / reference state
   int          pend[$];
   int          cur = 0, tb_out = 0, err_pct = 0, rdy_mode = 0, rdy_low = 0;
   bit          r_en = 1'b1, exp_err = 1'b0, prev_stall = 1'b0, start_req = 1'b0;
   logic [63:0] prev_addr, s_addr;
   logic [7:0]  prev_len;
   int          s_len;
   logic [63:0] obs_addr[$], exp_addr[$];
   int          obs_len[$], exp_len[$];

   task automatic step();
      int out_before;
      @(negedge clk);
      out_before = tb_out;
      if (prev_stall) begin
         chk("ar_hold_valid", ar_valid, 1);
         chk("ar_hold_addr", ar_addr, prev_addr);
         chk("ar_hold_len", ar_len, prev_len);
      end
      if (out_before >= MAX_OUT) chk("ar_full", ar_valid, 0);
      // R beats only for bursts accepted in an earlier cycle
      r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;
      if (r_en && (cur > 0 || pend.size() > 0) && $urandom_range(0, 2) != 0) begin
         if (cur == 0) cur = pend.pop_front();
         r_valid = 1'b1;
         r_last  = (cur == 1);
         if ($urandom_range(0, 99) < err_pct) r_resp = $urandom_range(0, 1) ? 2'b10 : 2'b11;
         else                                 r_resp = $urandom_range(0, 1) ? 2'b00 : 2'b01;
         if (r_resp[1]) exp_err = 1'b1;
         cur--;
         if (cur == 0) tb_out--;
      end
      case (rdy_mode)
         0: ar_ready = 1'b1;
         1: ar_ready = 1'($urandom_range(0, 1));
         default: begin
            ar_ready = (rdy_low == 0);
            if (rdy_low > 0) rdy_low--;
         end
      endcase
      if (ar_valid && ar_ready) begin
         obs_addr.push_back(ar_addr);
         obs_len.push_back(int'(ar_len));
         pend.push_back(int'(ar_len) + 1);
         tb_out++;
      end
      prev_stall = ar_valid && !ar_ready;
      prev_addr  = ar_addr;
      prev_len   = ar_len;
      init_read  = 1'b0;
      if (start_req) begin
         chk("start_ready", start_ready, 1);
         init_read       = 1'b1;
         read_start_addr = s_addr;
         read_length     = 32'(s_len);
         start_req       = 1'b0;
      end
   endtask

   task automatic build_model(input logic [63:0] addr, input int len);
      logic [63:0] a;
      int rem, room, s;
      exp_addr.delete(); exp_len.delete();
      a = addr & ~64'(BB - 1);
      rem = len;
      while (rem > 0) begin
         room = (4096 - int'(a % 64'd4096)) / BB;
         s = rem;
         if (s > MAX_BURST) s = MAX_BURST;
         if (s > room) s = room;
         exp_addr.push_back(a);
         exp_len.push_back(s - 1);
         a += 64'(s * BB);
         rem -= s;
      end
   endtask

   task automatic run_xfer(input logic [63:0] addr, input int len, input int rmode,
                           input int epct, input int hold);
      int n, m;
      build_model(addr, len);
      obs_addr.delete(); obs_len.delete();
      exp_err = 1'b0; err_pct = epct; rdy_mode = rmode; rdy_low = 5; r_en = (hold == 0);
      s_addr = addr; s_len = len; start_req = 1'b1;
      step();
      step();
      if (len == 0) begin
         chk("done_latency", read_done, 1);
         chk("no_ar_len0", ar_valid, 0);
      end else chk("ar_latency", ar_valid, 1);
      if (hold > 0) begin
         repeat (hold) step();
         m = (exp_addr.size() < MAX_OUT) ? exp_addr.size() : MAX_OUT;
         chk("hold_ar_count", obs_addr.size(), m);
         chk("hold_ar_valid", ar_valid, 0);
         r_en = 1'b1;
      end
      n = 0;
      while (!read_done && n < 5000) begin step(); n++; end
      chk("done_timeout", n < 5000, 1);
      chk("read_err", read_err, exp_err);
      chk("beats_left", pend.size() + cur, 0);
      chk("ar_count", obs_addr.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
         chk("ar_addr", obs_addr[i], exp_addr[i]);
         chk("ar_len", obs_len[i], exp_len[i]);
      end
      step();
      chk("done_pulse", read_done, 0);
      chk("back_idle", start_ready, 1);
   endtask

   initial begin
      #12;
      chk("rst_start_ready", start_ready, 1);
      chk("rst_ar_valid", ar_valid, 0);
      chk("rst_ar_addr", ar_addr, 0);
      chk("rst_ar_len", ar_len, 0);
      chk("rst_done", read_done, 0);
      chk("rst_err", read_err, 0);
      @(negedge clk) rst = 1'b0;
      chk("ar_size", ar_size, 3'd6);
      chk("ar_burst", ar_burst, 2'b01);

      run_xfer(64'h0, 16, 0, 0, 0);
      run_xfer(64'h0, 200, 0, 0, 0);
      run_xfer(64'hF80, 10, 0, 0, 0);
      run_xfer(64'h0, 640, 0, 0, 30);
      run_xfer(64'h0, 0, 0, 0, 0);
      run_xfer(64'h1234_5000, 16, 2, 0, 0);
      run_xfer(64'h0, 16, 0, 30, 0);
      run_xfer(64'hFFFF_FFFF_FFFF_F03F, 300, 1, 5, 0);

      // reset in the middle of a transfer, then stray R beats
      s_addr = 64'h0; s_len = 200; start_req = 1'b1; rdy_mode = 0; r_en = 1'b1; err_pct = 0;
      repeat (12) step();
      rst = 1'b1;
      #1;
      chk("midrst_ar_valid", ar_valid, 0);
      chk("midrst_start_ready", start_ready, 1);
      chk("midrst_ar_addr", ar_addr, 0);
      chk("midrst_done", read_done, 0);
      @(negedge clk);
      rst = 1'b0; pend.delete(); cur = 0; tb_out = 0; prev_stall = 1'b0;
      r_valid = 1'b1; r_last = 1'b1; r_resp = 2'b10;
      repeat (3) @(negedge clk);
      r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;
      chk("stray_err", read_err, 0);
      chk("stray_idle", start_ready, 1);
      run_xfer(64'h0, 300, 0, 0, 0);

      for (int t = 0; t < 20; t++)
         run_xfer({32'($urandom), 32'($urandom)}, $urandom_range(0, 400),
                  $urandom_range(0, 1), $urandom_range(0, 1) ? 0 : 3, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
